scc_tone_generator_nch: RTL and testbench

SCC_TONE_GENERATOR_NCH -- requirements
Module: scc_tone_generator_nch

---
 rtl/scc_tone_generator_nch.sv | 116 +++++++++++
 tb/tb_scc_tone_generator_nch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/scc_tone_generator_nch.sv
// Time-multiplexed SCC-style tone generator: one shared slot counter walks the
// channels, each keeping its own period, frequency counter, wave address and done flag.
module scc_tone_generator_nch #(
  parameter int  CH_NUM     = 5,
  parameter int  FREQ_W     = 12,
  parameter int  ADDR_W     = 5,
  parameter int  MIN_PERIOD = 8,
  localparam int SLOT_W     = (CH_NUM > 2) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              reg_wr,
  input  logic [SLOT_W-1:0] reg_ch,
  input  logic [FREQ_W-1:0] reg_period,
  input  logic              reg_wave_reset,
  input  logic [CH_NUM-1:0] oneshot,
  input  logic [CH_NUM-1:0] clear,
  output logic [SLOT_W-1:0] slot,
  output logic [ADDR_W-1:0] wave_address,
  output logic              wave_update,
  output logic [CH_NUM-1:0] done
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CH_NUM - 1);
  localparam logic [FREQ_W-1:0] MIN_P     = FREQ_W'(MIN_PERIOD);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [FREQ_W-1:0] period_q [CH_NUM];
  logic [FREQ_W-1:0] period_d [CH_NUM];
  logic [FREQ_W-1:0] count_q  [CH_NUM];
  logic [FREQ_W-1:0] count_d  [CH_NUM];
  logic [ADDR_W-1:0] addr_q   [CH_NUM];
  logic [ADDR_W-1:0] addr_d   [CH_NUM];
  logic [CH_NUM-1:0] done_q, done_d;

  logic [FREQ_W-1:0] curPeriod;
  logic [FREQ_W-1:0] curCount;
  logic [ADDR_W-1:0] curAddr;
  logic              halted;
  logic              endHit;

  assign curPeriod = period_q[slot_q];
  assign curCount  = count_q[slot_q];
  assign curAddr   = addr_q[slot_q];
  assign halted    = oneshot[slot_q] & done_q[slot_q];
  // Periods at or below MIN_PERIOD mean the tone is stopped, never an end event.
  assign endHit    = (curCount == curPeriod) && (curPeriod > MIN_P);

  assign slot         = slot_q;
  assign wave_address = curAddr;
  assign wave_update  = endHit & enable & ~halted;
  assign done         = done_q;

  always_comb begin
    slot_d   = slot_q;
    period_d = period_q;
    count_d  = count_q;
    addr_d   = addr_q;
    done_d   = done_q;

    if (reg_wr && (int'(reg_ch) < CH_NUM)) begin
      period_d[reg_ch] = reg_period;
    end

    if (enable) begin
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);

      if (!halted) begin
        if (endHit) begin
          count_d[slot_q] = '0;
          if (oneshot[slot_q] && (&curAddr)) begin
            done_d[slot_q] = 1'b1;
          end else begin
            addr_d[slot_q] = curAddr + ADDR_W'(1);
          end
        end else begin
          count_d[slot_q] = curCount + FREQ_W'(1);
        end
      end

      // Loop-mode channels drop any stale done flag; clear (key-on) wins over the slot update.
      for (int ch = 0; ch < CH_NUM; ch++) begin
        if (!oneshot[ch]) begin
          done_d[ch] = 1'b0;
        end
        if (clear[ch]) begin
          count_d[ch] = '0;
          done_d[ch]  = 1'b0;
          if (reg_wave_reset) begin
            addr_d[ch] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
      done_q <= '0;
      for (int ch = 0; ch < CH_NUM; ch++) begin
        period_q[ch] <= '0;
        count_q[ch]  <= '0;
        addr_q[ch]   <= '0;
      end
    end else begin
      slot_q   <= slot_d;
      period_q <= period_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_scc_tone_generator_nch.sv
// Directed bench for scc_tone_generator_nch: a 5-channel instance for the tone behaviour
// and an 8-channel instance for slot wrap, enable hold and mid-run reset.
module tb_scc_tone_generator_nch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        reg_wr = 1'b0;
  logic [2:0]  reg_ch = '0;
  logic [11:0] reg_period = '0;
  logic        reg_wave_reset = 1'b0;
  logic [4:0]  oneshot = '0;
  logic [4:0]  clear = '0;
  logic [2:0]  slot;
  logic [4:0]  wave_address;
  logic        wave_update;
  logic [4:0]  done;

  logic        reset8 = 1'b1;
  logic        enable8 = 1'b0;
  logic [2:0]  slot8;
  logic [4:0]  wave_address8;
  logic        wave_update8;
  logic [7:0]  done8;

  int checks = 0;
  int errors = 0;
  int expSlot = 0;

  always #5 clk = ~clk;

  scc_tone_generator_nch dut (
    .clk(clk), .reset(reset), .enable(enable), .reg_wr(reg_wr), .reg_ch(reg_ch),
    .reg_period(reg_period), .reg_wave_reset(reg_wave_reset), .oneshot(oneshot),
    .clear(clear), .slot(slot), .wave_address(wave_address),
    .wave_update(wave_update), .done(done)
  );

  scc_tone_generator_nch #(.CH_NUM(8)) dut8 (
    .clk(clk), .reset(reset8), .enable(enable8), .reg_wr(1'b0), .reg_ch(3'd0),
    .reg_period(12'd0), .reg_wave_reset(1'b0), .oneshot(8'd0),
    .clear(8'd0), .slot(slot8), .wave_address(wave_address8),
    .wave_update(wave_update8), .done(done8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic wr, input logic [2:0] ch,
                               input logic [11:0] per, input logic wres, input logic [4:0] clr);
    enable         = en;
    reg_wr         = wr;
    reg_ch         = ch;
    reg_period     = per;
    reg_wave_reset = wres;
    clear          = clr;
    #1;
  endtask

  // Inputs change at the falling edge; the slot the main DUT should show is tracked here.
  task automatic cycle();
    @(negedge clk);
    if (reset) expSlot = 0;
    else if (enable) expSlot = (expSlot == 4) ? 0 : expSlot + 1;
  endtask

  task automatic idle();
    cycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, 5'd0);
  endtask

  task automatic advanceTo(input int ch);
    int steps = 0;
    do begin
      idle();
      steps++;
    end while (expSlot != ch && steps < 16);
    checkOutput("slotArrive", 32'(slot), 32'(ch));
  endtask

  task automatic resetDut();
    cycle();
    reset   = 1'b1;
    oneshot = '0;
    applyStimulus(1'b0, 1'b0, 3'd0, 12'd0, 1'b0, 5'd0);
    cycle();
    cycle();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state and idle slot walk with every period at 0
    resetDut();
    checkOutput("rstSlot", 32'(slot), 0);
    checkOutput("rstAddr", 32'(wave_address), 0);
    checkOutput("rstUpdate", 32'(wave_update), 0);
    checkOutput("rstDone", 32'(done), 0);
    applyStimulus(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, 5'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("idleSlot", 32'(slot), 32'(i % 5));
      checkOutput("idleUpdate", 32'(wave_update), 0);
      idle();
    end

    // Loop channel 2 with period 9: an update every 10th visit, address wraps 31 -> 0
    resetDut();
    applyStimulus(1'b0, 1'b1, 3'd2, 12'd9, 1'b0, 5'd0);
    cycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, 5'd0);
    for (int k = 1; k <= 330; k++) begin
      advanceTo(2);
      checkOutput("loopUpdate", 32'(wave_update), 32'(k % 10 == 0));
      checkOutput("loopAddr", 32'(wave_address), 32'(((k - 1) / 10) % 32));
    end

    // Period write during the serviced cycle uses the old period; out-of-range channel ignored
    resetDut();
    applyStimulus(1'b0, 1'b1, 3'd3, 12'd9, 1'b0, 5'd0);
    cycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, 5'd0);
    for (int k = 1; k <= 9; k++) advanceTo(3);
    checkOutput("preEndUpdate", 32'(wave_update), 0);
    advanceTo(3);
    applyStimulus(1'b1, 1'b1, 3'd3, 12'd20, 1'b0, 5'd0);
    checkOutput("oldPeriodEnd", 32'(wave_update), 1);
    cycle();
    applyStimulus(1'b1, 1'b1, 3'd6, 12'd9, 1'b0, 5'd0);
    for (int j = 1; j <= 21; j++) begin
      advanceTo(3);
      checkOutput("newPeriodUpdate", 32'(wave_update), 32'(j == 21));
      checkOutput("newPeriodAddr", 32'(wave_address), 1);
    end
    checkOutput("newPeriodDone", 32'(done), 0);

    // One-shot channel 0: 32 updates then halt at address 31; back to loop resumes
    resetDut();
    oneshot = 5'b00001;
    applyStimulus(1'b0, 1'b1, 3'd0, 12'd9, 1'b0, 5'd0);
    cycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, 5'd0);
    for (int k = 1; k <= 330; k++) begin
      if (k > 1) advanceTo(0);
      if (k <= 320) begin
        checkOutput("shotUpdate", 32'(wave_update), 32'(k % 10 == 0));
        checkOutput("shotAddr", 32'(wave_address), 32'((k - 1) / 10));
        checkOutput("shotDoneLow", 32'(done), 0);
      end else begin
        checkOutput("haltUpdate", 32'(wave_update), 0);
        checkOutput("haltAddr", 32'(wave_address), 31);
        checkOutput("haltDone", 32'(done), 32'h1);
      end
    end
    advanceTo(1);
    oneshot = 5'b00000;
    #1;
    for (int r = 1; r <= 11; r++) begin
      advanceTo(0);
      checkOutput("resumeDone", 32'(done), 0);
      checkOutput("resumeUpdate", 32'(wave_update), 32'(r == 10));
      checkOutput("resumeAddr", 32'(wave_address), (r <= 10) ? 32'd31 : 32'd0);
    end

    // Clear on channel 1: disabled clear ignored, clear keeps address, wave reset zeroes it
    resetDut();
    applyStimulus(1'b0, 1'b1, 3'd1, 12'd9, 1'b0, 5'd0);
    cycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, 5'd0);
    for (int k = 1; k <= 73; k++) advanceTo(1);
    checkOutput("preClearAddr", 32'(wave_address), 7);
    cycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 12'd0, 1'b1, 5'b00010);
    cycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, 5'b00010);
    for (int j = 1; j <= 10; j++) begin
      advanceTo(1);
      checkOutput("clearKeepAddr", 32'(wave_address), 7);
      checkOutput("clearCountUpdate", 32'(wave_update), 32'(j == 10));
    end
    cycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 12'd0, 1'b1, 5'b00010);
    advanceTo(1);
    checkOutput("waveResetAddr", 32'(wave_address), 0);
    checkOutput("waveResetUpdate", 32'(wave_update), 0);

    // Eight-channel instance: enable hold, 7 -> 0 wrap, mid-run reset
    cycle();
    reset8  = 1'b0;
    enable8 = 1'b1;
    #1;
    checkOutput("ch8Start", 32'(slot8), 0);
    cycle();
    enable8 = 1'b0;
    #1;
    checkOutput("ch8Adv", 32'(slot8), 1);
    cycle();
    enable8 = 1'b1;
    #1;
    checkOutput("ch8Hold", 32'(slot8), 1);
    for (int i = 2; i <= 9; i++) begin
      cycle();
      #1;
      checkOutput("ch8Walk", 32'(slot8), 32'(i % 8));
    end
    reset8 = 1'b1;
    cycle();
    reset8  = 1'b0;
    enable8 = 1'b0;
    #1;
    checkOutput("ch8RstSlot", 32'(slot8), 0);
    checkOutput("ch8RstAddr", 32'(wave_address8), 0);
    checkOutput("ch8RstUpdate", 32'(wave_update8), 0);
    checkOutput("ch8RstDone", 32'(done8), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
